// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write-back, issue reservation and packed read ports.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  localparam int PEND_WIDTH = $clog2(DEPTH + 1);

  logic                           write_in;
  logic [ADDR_WIDTH-1:0]          write_addr_in;
  logic [DATA_WIDTH-1:0]          write_data_in;
  logic                           reserve_in;
  logic [ADDR_WIDTH-1:0]          reserve_addr_in;
  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr_in;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data_out;
  logic [NUM_READ-1:0]            read_busy_out;
  logic [PEND_WIDTH-1:0]          pending_out;

  modport master (
    output write_in, write_addr_in, write_data_in,
    output reserve_in, reserve_addr_in, read_addr_in,
    input  read_data_out, read_busy_out, pending_out
  );

  modport slave (
    input  write_in, write_addr_in, write_data_in,
    input  reserve_in, reserve_addr_in, read_addr_in,
    output read_data_out, read_busy_out, pending_out
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with per-entry busy scoreboard,
// optional write-to-read bypass and optional hardwired-zero entry 0.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         debugen_in,
  regfile_sb_if.slave  bus
);
  localparam int          PEND_WIDTH = $clog2(DEPTH + 1);
  localparam int unsigned DEPTH_U    = DEPTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [PEND_WIDTH-1:0] r_pending;

  logic [DEPTH-1:0]      w_busy_nxt;
  logic [PEND_WIDTH-1:0] w_pending_nxt;
  logic                  w_wr_ok;
  logic                  w_rsv_ok;
  logic                  w_unused_debug;

  // Trace output is a simulation concern; the strobe has no hardware effect.
  assign w_unused_debug = debugen_in;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < DEPTH_U) && !(ZERO_REG && (a == '0));
  endfunction

  assign w_wr_ok  = bus.write_in   && addr_ok(bus.write_addr_in);
  assign w_rsv_ok = bus.reserve_in && addr_ok(bus.reserve_addr_in);

  // Reserve is applied after the write so a same-address issue keeps the entry busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[bus.write_addr_in]   = 1'b0;
    if (w_rsv_ok) w_busy_nxt[bus.reserve_addr_in] = 1'b1;
  end

  always_comb begin
    w_pending_nxt = '0;
    for (int unsigned i = 0; i < DEPTH_U; i++)
      w_pending_nxt = w_pending_nxt + PEND_WIDTH'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) r_mem[i] <= '0;
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      if (w_wr_ok) r_mem[bus.write_addr_in] <= bus.write_data_in;
      r_busy    <= w_busy_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.pending_out = r_pending;

  always_comb begin
    logic [ADDR_WIDTH-1:0] w_ra;
    bus.read_data_out = '0;
    bus.read_busy_out = '0;
    for (int unsigned p = 0; p < NUM_READ; p++) begin
      w_ra = bus.read_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (!addr_ok(w_ra)) begin
        bus.read_data_out[p*DATA_WIDTH +: DATA_WIDTH] = '0;
        bus.read_busy_out[p]                          = 1'b0;
      end else if (BYPASS && bus.write_in && (bus.write_addr_in == w_ra)) begin
        bus.read_data_out[p*DATA_WIDTH +: DATA_WIDTH] = bus.write_data_in;
        bus.read_busy_out[p] = bus.reserve_in && (bus.reserve_addr_in == w_ra);
      end else begin
        bus.read_data_out[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ra];
        bus.read_busy_out[p]                          = r_busy[w_ra];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: one DUT with bypass, one without,
// both driven by the same stimulus.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic        write_in;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        reserve_in;
  logic [4:0]  reserve_addr;
  logic [4:0]  ra0, ra1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if_bp ();
  regfile_sb_if #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if_nb ();

  assign if_bp.write_in        = write_in;
  assign if_bp.write_addr_in   = write_addr;
  assign if_bp.write_data_in   = write_data;
  assign if_bp.reserve_in      = reserve_in;
  assign if_bp.reserve_addr_in = reserve_addr;
  assign if_bp.read_addr_in    = {ra1, ra0};
  assign if_nb.write_in        = write_in;
  assign if_nb.write_addr_in   = write_addr;
  assign if_nb.write_data_in   = write_data;
  assign if_nb.reserve_in      = reserve_in;
  assign if_nb.reserve_addr_in = reserve_addr;
  assign if_nb.read_addr_in    = {ra1, ra0};

  regfile_sb #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_READ(2),
               .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_bp (
    .clk(clk), .reset(reset), .debugen_in(1'b0), .bus(if_bp.slave));

  regfile_sb #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_READ(2),
               .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .reset(reset), .debugen_in(1'b0), .bus(if_nb.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_in   = 1'b0;
    reserve_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; write_in = 1'b0; write_addr = '0; write_data = '0;
    reserve_in = 1'b0; reserve_addr = '0; ra0 = '0; ra1 = '0;
    tick();
    reset = 1'b0;

    // Reset state: every address on both ports reads 0 / not busy.
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a);
      #1;
      check("rst_d0", if_bp.read_data_out[31:0],  32'h0);
      check("rst_d1", if_bp.read_data_out[63:32], 32'h0);
      check("rst_b",  32'(if_bp.read_busy_out),   32'h0);
    end
    check("rst_pend", 32'(if_bp.pending_out), 32'd0);

    // Write 0xDEADBEEF to 5 while port0 reads 5.
    write_in = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF; ra0 = 5'd5;
    #1;
    check("nb_old",  if_nb.read_data_out[31:0], 32'h0);
    check("bp_same", if_bp.read_data_out[31:0], 32'hDEADBEEF);
    tick(); idle();
    #1;
    check("nb_new",  if_nb.read_data_out[31:0], 32'hDEADBEEF);

    // Bypass on port1.
    write_in = 1'b1; write_addr = 5'd7; write_data = 32'h12345678; ra1 = 5'd7;
    #1;
    check("bp_d1", if_bp.read_data_out[63:32], 32'h12345678);
    check("bp_b1", 32'(if_bp.read_busy_out[1]), 32'd0);
    tick(); idle();

    // Hardwired zero entry ignores write and reserve.
    write_in = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF;
    reserve_in = 1'b1; reserve_addr = 5'd0; ra0 = 5'd0;
    #1;
    check("z_d",  if_bp.read_data_out[31:0], 32'h0);
    check("z_b",  32'(if_bp.read_busy_out[0]), 32'd0);
    tick(); idle();
    #1;
    check("z_d2",   if_bp.read_data_out[31:0], 32'h0);
    check("z_pend", 32'(if_bp.pending_out), 32'd0);

    // Scoreboard sequence.
    reserve_in = 1'b1; reserve_addr = 5'd3; ra0 = 5'd3;
    tick(); idle();
    check("sb_p1", 32'(if_bp.pending_out), 32'd1);
    check("sb_b3", 32'(if_bp.read_busy_out[0]), 32'd1);
    reserve_in = 1'b1; reserve_addr = 5'd9;
    tick(); idle();
    check("sb_p2", 32'(if_bp.pending_out), 32'd2);
    write_in = 1'b1; write_addr = 5'd3; write_data = 32'h33;
    reserve_in = 1'b1; reserve_addr = 5'd9;
    tick(); idle();
    check("sb_p3",  32'(if_bp.pending_out), 32'd1);
    check("sb_d3",  if_nb.read_data_out[31:0], 32'h33);
    check("sb_b3c", 32'(if_nb.read_busy_out[0]), 32'd0);
    write_in = 1'b1; write_addr = 5'd9; write_data = 32'h99;
    reserve_in = 1'b1; reserve_addr = 5'd9; ra1 = 5'd9;
    #1;
    check("sb_bp_d9", if_bp.read_data_out[63:32], 32'h99);
    check("sb_bp_b9", 32'(if_bp.read_busy_out[1]), 32'd1);
    tick(); idle();
    check("sb_p4",  32'(if_bp.pending_out), 32'd1);
    check("sb_b9",  32'(if_nb.read_busy_out[1]), 32'd1);
    check("sb_d9",  if_nb.read_data_out[63:32], 32'h99);

    // Build up four busy entries (9, 2, 4, 6) then reset mid-operation.
    for (int k = 0; k < 3; k++) begin
      reserve_in = 1'b1; reserve_addr = 5'(2 + 2 * k);
      tick();
    end
    idle();
    check("mid_p4", 32'(if_bp.pending_out), 32'd4);
    reset = 1'b1; write_in = 1'b1; write_addr = 5'd2; write_data = 32'hA5A5A5A5;
    tick();
    reset = 1'b0; idle();
    ra0 = 5'd2; ra1 = 5'd5;
    #1;
    check("mr_pend", 32'(if_bp.pending_out), 32'd0);
    check("mr_d2",   if_bp.read_data_out[31:0],  32'h0);
    check("mr_d5",   if_bp.read_data_out[63:32], 32'h0);
    check("mr_b",    32'(if_bp.read_busy_out),   32'h0);
    ra0 = 5'd9; ra1 = 5'd7;
    #1;
    check("mr_d9",   if_nb.read_data_out[31:0],  32'h0);
    check("mr_d7",   if_nb.read_data_out[63:32], 32'h0);
    check("mr_b9",   32'(if_nb.read_busy_out),   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
